mux_scan_serializer: RTL and testbench
======================================

# mux_scan_serializer

Upstream sequencer for the 16:1 mux tree. It accepts a 16-bit word through a valid/ready handshake and registers it, then steps the 4-bit select through all channels. Each selected channel goes out as a serial bit stream with its own valid/ready handshake. The block instantiates the team's 16:1 mux and owns its select lines, so downstream logic sees a clean, back-pressurable bit stream.

## Interface
Parameters:
- MSB_FIRST, default 0: 0 scans sel 0→15; 1 scans sel 15→0.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_data  input  16  word to serialize, captured on accept
- in_valid  input  1  upstream word available
- in_ready  output  1  block can accept a word (high only in IDLE)
- bit_out  output  1  current serial bit (mux output for current sel)
- bit_valid  output  1  bit_out is valid
- bit_ready  input  1  downstream accepts bit_out
- bit_last  output  1  current beat is the final beat of the word
- sel  output  4  current mux select, for debug/monitor
- busy  output  1  high in any state other than IDLE

Clock is clk; reset is rst, asynchronous and active-high.

## Operation
- States: IDLE, SHIFT, and PARITY (PARITY exists only with the macro).
- IDLE:
  - in_ready=1, bit_valid=0.
  - On in_valid&&in_ready: word_q←in_data; sel←0 (or 15 if MSB_FIRST); go to SHIFT.
- SHIFT:
  - bit_valid=1; bit_out=word_q[sel] via the mux16to1 instance.
  - On bit_valid&&bit_ready:
    - If sel is the terminal index (15, or 0 if MSB_FIRST), go to PARITY if compiled in, else to IDLE.
    - Otherwise sel increments (or decrements if MSB_FIRST).
  - With bit_ready=0, bit_out, sel and bit_last hold stable.
- bit_last is high in SHIFT at the terminal index when parity is compiled out, and in PARITY when compiled in.
- sel is a 4-bit register that never wraps: the terminal index always exits SHIFT.
- in_valid is ignored outside IDLE. in_data changes after accept have no effect.
- Outputs after reset: in_ready=1, bit_valid=0, bit_out=0, bit_last=0, sel=0 (15 if MSB_FIRST), busy=0; word_q=0; state=IDLE.
- Reset asserted mid-word aborts the word immediately. The remaining bits are never emitted, and the next accepted word starts from the initial sel.

## Timing
- Word accepted at edge N → first bit_valid at cycle N+1. There is no combinational in→out path.
- Each beat lasts ≥1 cycle; 1 beat per cycle when bit_ready is held high.
- Word throughput: 16 beats (17 with parity) plus 1 IDLE cycle before the next accept. in_ready deasserts the cycle after accept.
- bit_out, bit_valid and bit_last are driven purely from registers plus the mux tree, so there is no dependence on bit_ready within a cycle.
- Reset takes effect asynchronously; deassertion is synchronous to clk at the system level.

## Configuration
- MUX_SCAN_PARITY_EN defined:
  - After the 16th data beat, one extra PARITY beat is emitted with bit_out = ^word_q (even parity), bit_valid=1, bit_last=1, sel held at the terminal index.
  - The PARITY beat exits to IDLE on bit_ready.
- MUX_SCAN_PARITY_EN undefined:
  - The PARITY state and its logic are absent.
  - bit_last is asserted on the 16th data beat.
  - A word is exactly 16 beats.

## Structure
- Shared package mux_pkg:
  - state enum (IDLE, SHIFT, PARITY)
  - SEL_W=4, DATA_W=16, SEL_FIRST/SEL_LAST constants per scan direction
- One sub-module: the existing mux16to1 (built from mux4to1/mux2to1), fed by word_q and sel. No new sub-modules.

## Test plan
- Reset, then accept 16'hA5C3 with MSB_FIRST=0 and bit_ready=1 → bits 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 on consecutive cycles. bit_last only on beat 16, then in_ready=1 one cycle later.
- MSB_FIRST=1, word 16'h8001 → first beat 1, beats 2–15 all 0, beat 16 equal to 1. sel observed counting 15→0.
- Backpressure: word 16'h00F0, toggle bit_ready 1/0 every cycle → sel, bit_out and bit_last are stable while bit_ready=0. Exactly 16 accepted beats, data identical to the unstalled case.
- in_valid held high with new data during SHIFT → no second capture. The stream matches the first word, and the second word is accepted only after return to IDLE.
- Assert rst at beat 7 of word 16'hFFFF → bit_valid=0 and sel reset asynchronously. The next word 16'h0001 starts at bit 0 and yields 1 followed by fifteen 0s.
- With MUX_SCAN_PARITY_EN: word 16'h0007 → 16 data beats then parity beat=1 with bit_last=1. Word 16'h0003 → parity beat=0; 17 beats total.

Source files
------------

// File: rtl/mux_pkg.sv
// mux_pkg: shared types and constants for the mux scan serializer and its
// 16:1 mux tree. Holds the FSM state encoding, the select/data widths and the
// first/terminal select index for each scan direction.
package mux_pkg;

  localparam int SEL_W  = 4;
  localparam int DATA_W = 16;

  // PARITY is only ever entered when MUX_SCAN_PARITY_EN is defined.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  // Scan endpoints for LSB-first (sel 0 -> 15) and MSB-first (sel 15 -> 0).
  localparam logic [SEL_W-1:0] SEL_FIRST_LSB = 4'd0;
  localparam logic [SEL_W-1:0] SEL_LAST_LSB  = 4'd15;
  localparam logic [SEL_W-1:0] SEL_FIRST_MSB = 4'd15;
  localparam logic [SEL_W-1:0] SEL_LAST_MSB  = 4'd0;

  function automatic logic [SEL_W-1:0] sel_first(input bit msb_first);
    return msb_first ? SEL_FIRST_MSB : SEL_FIRST_LSB;
  endfunction

  function automatic logic [SEL_W-1:0] sel_last(input bit msb_first);
    return msb_first ? SEL_LAST_MSB : SEL_LAST_LSB;
  endfunction

  // Next select in scan order. Never called at the terminal index, so the
  // select register never wraps.
  function automatic logic [SEL_W-1:0] sel_step(input logic [SEL_W-1:0] s,
                                                input bit               msb_first);
    return msb_first ? (s - SEL_W'(1)) : (s + SEL_W'(1));
  endfunction

endpackage

// File: rtl/mux16to1.sv
// mux16to1: the team's 16:1 mux tree, built from mux4to1 stages which are in
// turn built from mux2to1 cells. Purely combinational.

// 2:1 mux cell.
module mux2to1 (
  input  logic a,
  input  logic b,
  input  logic s,
  output logic y
);
  assign y = s ? b : a;
endmodule

// 4:1 mux from three 2:1 cells; s[0] picks within pairs, s[1] between pairs.
module mux4to1 (
  input  logic [3:0] d,
  input  logic [1:0] s,
  output logic       y
);
  logic lo;
  logic hi;

  mux2to1 u_lo  (.a(d[0]), .b(d[1]), .s(s[0]), .y(lo));
  mux2to1 u_hi  (.a(d[2]), .b(d[3]), .s(s[0]), .y(hi));
  mux2to1 u_out (.a(lo),   .b(hi),   .s(s[1]), .y(y));
endmodule

// 16:1 mux from five 4:1 stages; s[1:0] picks within nibbles, s[3:2] picks the nibble.
module mux16to1 (
  input  logic [15:0] d,
  input  logic [3:0]  s,
  output logic        y
);
  logic [3:0] nib;

  for (genvar g = 0; g < 4; g++) begin : g_leaf
    mux4to1 u_leaf (.d(d[4*g +: 4]), .s(s[1:0]), .y(nib[g]));
  end

  mux4to1 u_root (.d(nib), .s(s[3:2]), .y(y));
endmodule

// File: rtl/mux_scan_serializer.sv
// mux_scan_serializer: accepts a 16-bit word over a valid/ready handshake,
// then steps the 16:1 mux select across every channel and emits one serial
// bit per beat over a second valid/ready handshake.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; a valid source holds its data stable until that edge, and
// ready may change freely without affecting the other side's outputs.
//
// Optional feature: define MUX_SCAN_PARITY_EN to append one even-parity beat
// after the 16 data beats. Without it a word is exactly 16 beats.
//
// FSM state is visible through busy (non-IDLE) and sel (current channel).
module mux_scan_serializer
  import mux_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              bit_out,
  output logic              bit_valid,
  input  logic              bit_ready,
  output logic              bit_last,
  output logic [SEL_W-1:0]  sel,
  output logic              busy
);

  localparam logic [SEL_W-1:0] SEL_FIRST = sel_first(MSB_FIRST);
  localparam logic [SEL_W-1:0] SEL_LAST  = sel_last(MSB_FIRST);

  state_t            state;
  logic [DATA_W-1:0] word_q;
  logic              mux_y;

  // The mux tree reads the captured word at the current select.
  mux16to1 u_mux (.d(word_q), .s(sel), .y(mux_y));

  // Sequencer: capture in IDLE, step the select on each accepted beat, and
  // hold every registered output while the downstream stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      word_q    <= '0;
      sel       <= SEL_FIRST;
      in_ready  <= 1'b1;
      bit_valid <= 1'b0;
      bit_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            word_q    <= in_data;
            sel       <= SEL_FIRST;
            state     <= SHIFT;
            in_ready  <= 1'b0;
            bit_valid <= 1'b1;
            bit_last  <= 1'b0;
          end
        end
        SHIFT: begin
          if (bit_ready) begin
            if (sel == SEL_LAST) begin
`ifdef MUX_SCAN_PARITY_EN
              // sel stays at the terminal index through the parity beat.
              state     <= PARITY;
              bit_last  <= 1'b1;
`else
              state     <= IDLE;
              in_ready  <= 1'b1;
              bit_valid <= 1'b0;
              bit_last  <= 1'b0;
`endif
            end else begin
              sel <= sel_step(sel, MSB_FIRST);
`ifndef MUX_SCAN_PARITY_EN
              // Last is flagged on the beat that will present the terminal index.
              bit_last <= (sel_step(sel, MSB_FIRST) == SEL_LAST);
`endif
            end
          end
        end
`ifdef MUX_SCAN_PARITY_EN
        PARITY: begin
          if (bit_ready) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            bit_valid <= 1'b0;
            bit_last  <= 1'b0;
          end
        end
`endif
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          bit_valid <= 1'b0;
          bit_last  <= 1'b0;
        end
      endcase
    end
  end

`ifdef MUX_SCAN_PARITY_EN
  // The parity beat replaces the mux output with the even parity of the word.
  assign bit_out = (state == PARITY) ? ^word_q : mux_y;
`else
  assign bit_out = mux_y;
`endif

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mux_scan_serializer.sv
// tb_mux_scan_serializer: directed bench for mux_scan_serializer. Two
// instances share the clock and reset: dut0 scans LSB-first, dut1 MSB-first.
// Expected streams are hand-written bit strings in beat order, loaded into a
// scoreboard queue and consumed as beats are accepted.
module tb_mux_scan_serializer;

`ifdef MUX_SCAN_PARITY_EN
  localparam int BEATS = 17;
`else
  localparam int BEATS = 16;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] in_data   [2];
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic        bit_out   [2];
  logic        bit_valid [2];
  logic        bit_ready [2];
  logic        bit_last  [2];
  logic [3:0]  sel       [2];
  logic        busy      [2];

  mux_scan_serializer #(.MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst(rst),
    .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .bit_out(bit_out[0]), .bit_valid(bit_valid[0]), .bit_ready(bit_ready[0]),
    .bit_last(bit_last[0]), .sel(sel[0]), .busy(busy[0])
  );

  mux_scan_serializer #(.MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst(rst),
    .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .bit_out(bit_out[1]), .bit_valid(bit_valid[1]), .bit_ready(bit_ready[1]),
    .bit_last(bit_last[1]), .sel(sel[1]), .busy(busy[1])
  );

  // ---------------- scoreboard ----------------
  logic [0:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  // Load the expected stream: 16 data bits in beat order, then parity if built in.
  task automatic load_exp(input string bits, input logic par);
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(bits[i] == "1");
`ifdef MUX_SCAN_PARITY_EN
    exp_q.push_back(par);
`else
    if (par === 1'bx) exp_q.push_back(1'b0); // par is always 0/1; keeps the argument used
`endif
  endtask

  // ---------------- driver tasks ----------------
  // Offer a word at a negedge; it is taken at the next posedge. With hold set,
  // in_valid stays high and in_data switches to next_w after the accept.
  task automatic accept(input int d, input logic [15:0] w, input bit hold,
                        input logic [15:0] next_w, input string name);
    checks++;
    if (in_ready[d] !== 1'b1) begin
      errors++; $display("FAIL %s accept in_ready: got %b expected 1", name, in_ready[d]);
    end
    in_data[d]  = w;
    in_valid[d] = 1'b1;
    @(negedge clk);
    in_data[d]  = hold ? next_w : 16'hDEAD;
    in_valid[d] = hold;
    checks++;
    if ({bit_valid[d], in_ready[d], busy[d]} !== 3'b101) begin
      errors++;
      $display("FAIL %s first beat valid/in_ready/busy: got %b%b%b expected 101",
               name, bit_valid[d], in_ready[d], busy[d]);
    end
  endtask

  // Consume beats until bit_valid drops. mode 1 toggles bit_ready 1/0 per cycle.
  task automatic collect(input int d, input int mode, input string name);
    int k = 0;
    int cyc = 0;
    bit stalled = 1'b0;
    logic [5:0] held = '0;
    logic [3:0] exp_sel;
    logic [0:0] e;
    while (bit_valid[d] === 1'b1 && cyc < 200) begin
      if (stalled) begin
        checks++;
        if ({bit_out[d], sel[d], bit_last[d]} !== held) begin
          errors++;
          $display("FAIL %s stall hold beat %0d: got %b expected %b",
                   name, k, {bit_out[d], sel[d], bit_last[d]}, held);
        end
      end
      bit_ready[d] = (mode == 1) ? (cyc % 2 == 0) : 1'b1;
      if (bit_ready[d]) begin
        if (k < 16) exp_sel = d ? 4'(15 - k) : 4'(k);
        else        exp_sel = d ? 4'd0 : 4'd15;
        checks++;
        if (sel[d] !== exp_sel) begin
          errors++; $display("FAIL %s sel beat %0d: got %0d expected %0d", name, k, sel[d], exp_sel);
        end
        if (exp_q.size() == 0) begin
          errors++; checks++;
          $display("FAIL %s extra beat %0d: got bit %b expected none", name, k, bit_out[d]);
        end else begin
          e = exp_q.pop_front();
          checks++;
          if (bit_out[d] !== e) begin
            errors++; $display("FAIL %s bit beat %0d: got %b expected %b", name, k, bit_out[d], e);
          end
          checks++;
          if (bit_last[d] !== (exp_q.size() == 0)) begin
            errors++;
            $display("FAIL %s bit_last beat %0d: got %b expected %b", name, k, bit_last[d], exp_q.size() == 0);
          end
        end
        k++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held = {bit_out[d], sel[d], bit_last[d]};
      end
      cyc++;
      @(negedge clk);
    end
    bit_ready[d] = 1'b0;
    if (cyc >= 200) begin
      errors++; checks++;
      $display("FAIL %s timeout: got %0d beats expected %0d", name, k, BEATS);
    end
    checks++;
    if (k != BEATS || exp_q.size() != 0) begin
      errors++; $display("FAIL %s beat count: got %0d expected %0d", name, k, BEATS);
    end
    checks++;
    if ({in_ready[d], busy[d], bit_last[d]} !== 3'b100) begin
      errors++;
      $display("FAIL %s after word in_ready/busy/last: got %b%b%b expected 100",
               name, in_ready[d], busy[d], bit_last[d]);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({in_ready[d], bit_valid[d], bit_out[d], bit_last[d], busy[d]} !== 5'b10000) begin
        errors++;
        $display("FAIL reset flags dut%0d: got %b expected 10000", d,
                 {in_ready[d], bit_valid[d], bit_out[d], bit_last[d], busy[d]});
      end
      checks++;
      if (sel[d] !== (d ? 4'd15 : 4'd0)) begin
        errors++; $display("FAIL reset sel dut%0d: got %0d expected %0d", d, sel[d], d ? 15 : 0);
      end
    end
  endtask

  task automatic test_lsb_first();
    load_exp("1100001110100101", 1'b0);
    accept(0, 16'hA5C3, 1'b0, 16'h0, "lsb_a5c3");
    collect(0, 0, "lsb_a5c3");
  endtask

  task automatic test_msb_first();
    load_exp("1000000000000001", 1'b0);
    accept(1, 16'h8001, 1'b0, 16'h0, "msb_8001");
    collect(1, 0, "msb_8001");
  endtask

  task automatic test_backpressure();
    load_exp("0000111100000000", 1'b0);
    accept(0, 16'h00F0, 1'b0, 16'h0, "bp_00f0");
    collect(0, 1, "bp_00f0");
  endtask

  task automatic test_back_to_back();
    load_exp("1100001110100101", 1'b0);
    accept(0, 16'hA5C3, 1'b1, 16'h1234, "hold_first");
    collect(0, 0, "hold_first");
    @(negedge clk);
    in_valid[0] = 1'b0;
    checks++;
    if ({bit_valid[0], in_ready[0]} !== 2'b10) begin
      errors++;
      $display("FAIL hold second accept valid/in_ready: got %b%b expected 10", bit_valid[0], in_ready[0]);
    end
    load_exp("0010110001001000", 1'b1);
    collect(0, 0, "hold_second");
  endtask

  task automatic test_reset_abort();
    accept(0, 16'hFFFF, 1'b0, 16'h0, "abort_ffff");
    bit_ready[0] = 1'b1;
    for (int i = 0; i < 6; i++) @(negedge clk);
    checks++;
    if (sel[0] !== 4'd6) begin
      errors++; $display("FAIL abort beat7 sel: got %0d expected 6", sel[0]);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bit_valid[0], bit_last[0], busy[0], in_ready[0]} !== 4'b0001 || sel[0] !== 4'd0) begin
      errors++;
      $display("FAIL abort async reset: got valid/last/busy/rdy %b sel %0d expected 0001 sel 0",
               {bit_valid[0], bit_last[0], busy[0], in_ready[0]}, sel[0]);
    end
    checks++;
    if (sel[1] !== 4'd15) begin
      errors++; $display("FAIL abort reset sel dut1: got %0d expected 15", sel[1]);
    end
    bit_ready[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    load_exp("1000000000000000", 1'b1);
    accept(0, 16'h0001, 1'b0, 16'h0, "abort_next_0001");
    collect(0, 0, "abort_next_0001");
  endtask

  task automatic test_parity();
    load_exp("1110000000000000", 1'b1);
    accept(0, 16'h0007, 1'b0, 16'h0, "par_0007");
    collect(0, 0, "par_0007");
    load_exp("1100000000000000", 1'b0);
    accept(0, 16'h0003, 1'b0, 16'h0, "par_0003");
    collect(0, 0, "par_0003");
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int d = 0; d < 2; d++) begin
      in_data[d]   = '0;
      in_valid[d]  = 1'b0;
      bit_ready[d] = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_lsb_first();
    test_msb_first();
    test_backpressure();
    test_back_to_back();
    test_reset_abort();
    test_parity();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
